key_event_decoder: RTL and testbench

- Consumes the debounced, active-high "switch is pressed" level produced by the switch debouncer, running on the same slow tick clock.
- Turns that level into single-cycle key events: press, release, long-press and auto-repeat.
- Keeps a saturating count of auto-repeats for the current hold.
- Sits between the debouncer and the UI/control logic, so downstream logic never has to edge-detect or time key holds itself.

---
 rtl/key_event_decoder_if.sv | 30 +++
 rtl/key_event_decoder.sv | 113 +++++++++++
 tb/tb_key_event_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_event_decoder_if
// Purpose  : Key level input and key event outputs of key_event_decoder.
//            master = the side that drives the key level and consumes events,
//            slave  = the decoder itself.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface key_event_decoder_if #(
  parameter int CNT_W = 8
);
  logic             ispressedin;
  logic             pressout;
  logic             releaseout;
  logic             longout;
  logic             repeatout;
  logic             holdingout;
  logic [CNT_W-1:0] holdcount;

  modport master (
    output ispressedin,
    input  pressout, releaseout, longout, repeatout, holdingout, holdcount
  );

  modport slave (
    input  ispressedin,
    output pressout, releaseout, longout, repeatout, holdingout, holdcount
  );
endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_event_decoder
// Purpose  : Turns a debounced key level into single-cycle press, release,
//            long-press and auto-repeat events, and keeps a saturating count
//            of auto-repeats for the current (or most recent) hold.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module key_event_decoder #(
  parameter int LONG_TICKS   = 200,
  parameter int REPEAT_TICKS = 50,
  parameter int CNT_W        = 8
) (
  input  wire                 chatterclock,
  input  wire                 reset,
  key_event_decoder_if.slave  kif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LONG   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] C_REPEAT = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX    = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_repeat;
  logic             r_holding;
  logic [CNT_W-1:0] r_holdcount;

  // Key event state machine; every output is a register. A release seen on
  // the same edge as a timeout takes priority over the timeout.
  always_ff @(posedge chatterclock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_holding   <= 1'b0;
      r_holdcount <= '0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (kif.ispressedin) begin
            r_state     <= HELD;
            r_timer     <= C_ONE;
            r_press     <= 1'b1;
            r_holding   <= 1'b1;
            r_holdcount <= '0;
          end
        end
        HELD: begin
          if (!kif.ispressedin) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_release <= 1'b1;
            r_holding <= 1'b0;
          end else if (r_timer == C_LONG) begin
            r_state <= REPEAT;
            r_timer <= C_ONE;
            r_long  <= 1'b1;
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end
        REPEAT: begin
          if (!kif.ispressedin) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_release <= 1'b1;
            r_holding <= 1'b0;
          end else if (r_timer == C_REPEAT) begin
            r_timer  <= C_ONE;
            r_repeat <= 1'b1;
            if (r_holdcount != C_MAX) begin
              r_holdcount <= r_holdcount + C_ONE;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_timer   <= '0;
          r_holding <= 1'b0;
        end
      endcase
    end
  end

  assign kif.pressout   = r_press;
  assign kif.releaseout = r_release;
  assign kif.longout    = r_long;
  assign kif.repeatout  = r_repeat;
  assign kif.holdingout = r_holding;
  assign kif.holdcount  = r_holdcount;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_key_event_decoder
// Purpose  : Scoreboard bench for key_event_decoder. Two instances
//            (LONG=10/REPEAT=4 and LONG=2/REPEAT=1) share one key stream; a
//            hold-age reference model queues the expected outputs per edge
//            and a monitor pops and compares them one step after each edge.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int CNT_W = 8;
  localparam int HCMAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             p;
    logic             r;
    logic             l;
    logic             rp;
    logic             h;
    logic [CNT_W-1:0] hc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  key_event_decoder_if #(.CNT_W(CNT_W)) ifc0 ();
  key_event_decoder_if #(.CNT_W(CNT_W)) ifc1 ();

  key_event_decoder #(.LONG_TICKS(10), .REPEAT_TICKS(4), .CNT_W(CNT_W)) dut0 (
    .chatterclock(clk),
    .reset       (rst),
    .kif         (ifc0)
  );

  key_event_decoder #(.LONG_TICKS(2), .REPEAT_TICKS(1), .CNT_W(CNT_W)) dut1 (
    .chatterclock(clk),
    .reset       (rst),
    .kif         (ifc1)
  );

  always #5 clk = ~clk;

  // Reference model: key age measured in edges since the press edge
  int   m_long[2] = '{10, 2};
  int   m_rep[2]  = '{4, 1};
  bit   m_held[2];
  int   m_age[2];
  int   m_hc[2];
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t model_edge(int u, bit key);
    exp_t e;
    e = '0;
    if (!m_held[u]) begin
      if (key) begin
        m_held[u] = 1'b1;
        m_age[u]  = 0;
        m_hc[u]   = 0;
        e.p       = 1'b1;
      end
    end else if (!key) begin
      m_held[u] = 1'b0;
      e.r       = 1'b1;
    end else begin
      m_age[u] = m_age[u] + 1;
      if (m_age[u] == m_long[u]) begin
        e.l = 1'b1;
      end else if (m_age[u] > m_long[u] && ((m_age[u] - m_long[u]) % m_rep[u]) == 0) begin
        e.rp = 1'b1;
        if (m_hc[u] < HCMAX) m_hc[u] = m_hc[u] + 1;
      end
    end
    e.h  = m_held[u];
    e.hc = CNT_W'(m_hc[u]);
    return e;
  endfunction

  // Called just after a negedge: drive the key for the next edge, queue expectations
  task automatic step(bit key);
    ifc0.ispressedin = key;
    ifc1.ispressedin = key;
    q0.push_back(model_edge(0, key));
    q1.push_back(model_edge(1, key));
    @(negedge clk);
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  function automatic exp_t act0();
    return {ifc0.pressout, ifc0.releaseout, ifc0.longout, ifc0.repeatout,
            ifc0.holdingout, ifc0.holdcount};
  endfunction

  function automatic exp_t act1();
    return {ifc1.pressout, ifc1.releaseout, ifc1.longout, ifc1.repeatout,
            ifc1.holdingout, ifc1.holdcount};
  endfunction

  task automatic check_vec(string name, int cyc, exp_t got, exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got p=%b r=%b l=%b rp=%b h=%b hc=%0d, expected p=%b r=%b l=%b rp=%b h=%b hc=%0d",
               name, cyc, got.p, got.r, got.l, got.rp, got.h, got.hc,
               want.p, want.r, want.l, want.rp, want.h, want.hc);
    end
    checks++;
    if ($countones({got.p, got.r, got.l, got.rp}) > 1) begin
      errors++;
      $display("FAIL %s_exclusive cycle %0d: got pulses %b, expected at most one high",
               name, cyc, {got.p, got.r, got.l, got.rp});
    end
  endtask

  // Monitor: one step after every edge outside reset, compare against the queue head
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        checks++;
        if (q0.size() == 0 || q1.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow cycle %0d: got q0=%0d q1=%0d entries, expected at least 1 each",
                   cyc, q0.size(), q1.size());
        end else begin
          check_vec("dut0", cyc, act0(), q0.pop_front());
          check_vec("dut1", cyc, act1(), q1.pop_front());
        end
      end
    end
  end

  // Asynchronous reset while the key stays at its current level
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_vec("reset_async0", -1, act0(), exp_t'(0));
    check_vec("reset_async1", -1, act1(), exp_t'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_held[u] = 1'b0;
      m_age[u]  = 0;
      m_hc[u]   = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc0.ispressedin = 1'b0;
    ifc1.ispressedin = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_held[u] = 1'b0;
      m_age[u]  = 0;
      m_hc[u]   = 0;
    end
    rst = 1'b1;
    #1;
    check_vec("reset_state0", 0, act0(), exp_t'(0));
    check_vec("reset_state1", 0, act1(), exp_t'(0));
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(3);

    // Short hold: release before the long-press point
    hold(5);
    idle(4);
    // 22-edge hold: release coincides with third repeat timeout on dut0
    hold(22);
    idle(4);
    // Release sampled exactly at the long-press edge of dut0
    hold(10);
    idle(4);
    // Minimum presses back to back
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    idle(3);
    // Long hold: dut1 saturates holdcount at 255
    hold(300);
    idle(5);
    // Next press clears holdcount
    hold(3);
    idle(3);
    // Reset in the middle of REPEAT with the key still held
    hold(15);
    do_reset();
    hold(4);
    idle(3);

    // Randomised holds and gaps
    for (int t = 0; t < 40; t++) begin
      hold($urandom_range(1, 40));
      idle($urandom_range(1, 6));
    end
    for (int t = 0; t < 200; t++) step(1'(($urandom >> 3) & 1));
    idle(4);

    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got q0=%0d q1=%0d entries left, expected 0",
               q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
